tinyqv_nibble_ram: RTL

Nibble-serial scratchpad RAM that acts as the memory responder for the TinyQV core's load/store port. It consumes the core's 4-bit-per-clock store stream, the 28-bit address and the `address_ready` strobe, holds a small word-organised memory, and returns load data as a nibble stream with `load_data_ready`. All transfers are timed to the core's free-running 3-bit sub-cycle `counter`.

---
 rtl/tinyqv_nibble_ram.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tinyqv_nibble_ram.sv
// tinyqv_nibble_ram: nibble-serial scratchpad RAM answering the TinyQV load/store port.
// Stores are written on the address round. Loads return a nibble stream after WAIT_ROUNDS idle rounds.
// Optional build macro TINYQV_RAM_ZERO_INIT_EN: zero-fill every word after reset (busy meanwhile).

module tinyqv_nibble_ram #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_ROUNDS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  counter,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [27:0] addr,
  input  logic        address_ready,
  input  logic [3:0]  store_data,
  output logic [3:0]  load_data,
  output logic        load_data_ready,
  output logic        busy,
  output logic        error
);
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int RW        = (WAIT_ROUNDS < 2) ? 1 : $clog2(WAIT_ROUNDS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic [ADDR_BITS-1:0] widx;
    logic [1:0]           off;
    logic [2:0]           nbytes;
    logic                 bad;
  } req_t;

  logic [31:0] mem [DEPTH];

  req_t                      req;
  logic [31:0]               sreg, st_word, wr_shift, rd_word, rd_shift, ld_word;
  logic [4:0]                sh;
  logic [2:0]                lo, hi;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_ld;
  logic [1:0]                state;
  logic [RW-1:0]             rounds;
  logic [31:0]               dsr;
  logic                      busy_q, init_run;
  logic                      data_last, blocked, req_fire, accept, st_wr, ld_acc;
  logic                      unused_sign;

  // Sign extension is done by the core, so the unsigned flag carries no meaning here.
  assign unused_sign = mem_op[2];

  // Word as it stands at counter==7: the live nibble on top of the seven already captured.
  assign st_word = {store_data, sreg[31:4]};

  // Store nibble stream capture, low nibble first
  always_ff @(posedge clk) begin
    if (rst)           sreg <= '0;
    else if (is_store) sreg <= st_word;
  end

  // Request decode: word index, byte offset, access size and rejection
  always_comb begin
    req        = '0;
    req.widx   = addr[ADDR_BITS+1:2];
    req.off    = addr[1:0];
    case (mem_op[1:0])
      2'b00:   req.nbytes = 3'd1;
      2'b01:   req.nbytes = 3'd2;
      2'b10:   req.nbytes = 3'd4;
      default: req.nbytes = 3'd0;
    endcase
    req.bad = (mem_op[1:0] == 2'b11)
           || (mem_op[1:0] == 2'b01 && addr[0])
           || (mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00)
           || ((addr >> (ADDR_BITS + 2)) != 28'd0);
  end

  assign sh       = {req.off, 3'b000};
  assign wr_shift = st_word << sh;
  assign rd_word  = mem[req.widx];
  assign rd_shift = rd_word >> sh;
  assign lo       = {1'b0, req.off};
  assign hi       = lo + req.nbytes;
  assign ld_word  = lane_ld;

  // Per byte lane: store enable inside [off, off+size), load byte kept only below the size
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [2:0] LANE = 3'(g);
    assign lane_we[g] = !req.bad && (LANE >= lo) && (LANE < hi);
    assign lane_ld[g] = (!req.bad && (LANE < req.nbytes)) ? rd_shift[8*g +: 8] : 8'h00;
  end

  // The last data clock counts as free so a back-to-back request can land there.
  assign data_last = (state == ST_DATA) && (counter == 3'd7);
  assign blocked   = init_run || ((state != ST_IDLE) && !data_last);
  assign req_fire  = address_ready && (counter == 3'd7);
  assign accept    = req_fire && !blocked && !rst;
  assign st_wr     = accept && is_store && !req.bad;
  assign ld_acc    = accept && is_load;

`ifdef TINYQV_RAM_ZERO_INIT_EN
  logic [ADDR_BITS-1:0] init_cnt;

  // Zero-fill sweep, one word per clock once reset releases
  always_ff @(posedge clk) begin
    if (rst) begin
      init_run <= 1'b1;
      init_cnt <= '0;
    end else if (init_run) begin
      init_cnt <= init_cnt + 1'b1;
      if (&init_cnt) init_run <= 1'b0;
    end
  end

  // Memory array: init sweep has priority, otherwise byte-masked store
  always_ff @(posedge clk) begin
    if (!rst && init_run) begin
      mem[init_cnt] <= '0;
    end else if (st_wr) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_we[i]) mem[req.widx][8*i +: 8] <= wr_shift[8*i +: 8];
    end
  end
`else
  assign init_run = 1'b0;

  // Memory array: byte-masked store on the accepting clock
  always_ff @(posedge clk) begin
    if (st_wr) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_we[i]) mem[req.widx][8*i +: 8] <= wr_shift[8*i +: 8];
    end
  end
`endif

  assign busy = busy_q | init_run;

  // Load sequencer: wait rounds, then one 8-clock data round; error pulse on reject/drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rounds          <= '0;
      dsr             <= '0;
      busy_q          <= 1'b0;
      load_data_ready <= 1'b0;
      load_data       <= 4'h0;
      error           <= 1'b0;
    end else begin
      error <= req_fire && (blocked || req.bad);
      case (state)
        ST_WAIT: begin
          if (counter == 3'd7) begin
            if (rounds <= RW'(1)) begin
              state           <= ST_DATA;
              load_data_ready <= 1'b1;
              load_data       <= dsr[3:0];
              dsr             <= dsr >> 4;
            end else begin
              rounds <= rounds - 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (counter == 3'd7) begin
            state           <= ST_IDLE;
            load_data_ready <= 1'b0;
            busy_q          <= 1'b0;
            load_data       <= 4'h0;
          end else begin
            load_data <= dsr[3:0];
            dsr       <= dsr >> 4;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A rejected load still plays out its data round, with zero data and busy low.
      if (ld_acc) begin
        state  <= ST_WAIT;
        rounds <= RW'(WAIT_ROUNDS);
        dsr    <= req.bad ? 32'h0 : ld_word;
        busy_q <= !req.bad;
      end
    end
  end

endmodule
